// File: rtl/prco_fetch.sv
// Instruction fetch stage: one outstanding word request, a one-entry instruction
// holding register toward decode, and branch redirect with kill of in-flight data.
// Optional halt-opcode support is compiled in with PRCO_FETCH_HALT_EN.
module prco_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_en,
   input  logic        i_stall,
   input  logic        i_branch,
   input  logic [15:0] i_branch_target,
   output logic        q_mem_req,
   output logic [15:0] q_mem_addr,
   input  logic        i_mem_ack,
   input  logic [15:0] i_mem_data,
   output logic [15:0] q_instr,
   output logic        q_instr_valid,
   output logic [15:0] q_pc,
   output logic        q_halted,
   output logic [1:0]  q_state
);

   // Memory side: q_mem_req/q_mem_addr stay constant from issue until the cycle
   // with i_mem_ack=1. Decode side: an instruction moves when q_instr_valid=1
   // and i_stall=0.
`ifdef PRCO_FETCH_HALT_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2, S_HALT = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2} state_t;
`endif

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [15:0] ipc_q, ipc_d;
   logic        kill_q, kill_d;
   logic [15:0] next_pc;

`ifdef PRCO_FETCH_HALT_EN
   logic halted_q, halted_d;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      valid_d = valid_q;
      ipc_d   = ipc_q;
      kill_d  = kill_q;
`ifdef PRCO_FETCH_HALT_EN
      halted_d = halted_q;
`endif
      // A branch in the same cycle always wins as the next fetch address.
      next_pc = i_branch ? i_branch_target : pc_q;

      case (state_q)
         S_IDLE: begin
            pc_d = next_pc;
            if (i_en) begin
               state_d = S_REQ;
               req_d   = 1'b1;
               addr_d  = next_pc;
            end
         end
         S_REQ: begin
            if (i_mem_ack) begin
               if (i_branch || kill_q) begin
                  // Returned word belongs to an abandoned path.
                  kill_d  = 1'b0;
                  valid_d = 1'b0;
                  pc_d    = next_pc;
                  req_d   = i_en;
                  if (i_en) begin
                     state_d = S_REQ;
                     addr_d  = next_pc;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  instr_d = i_mem_data;
                  valid_d = 1'b1;
                  ipc_d   = addr_q;
                  pc_d    = addr_q + 16'd1;
                  req_d   = 1'b0;
                  state_d = S_HOLD;
               end
            end else if (i_branch) begin
               kill_d  = 1'b1;
               valid_d = 1'b0;
               pc_d    = i_branch_target;
            end
         end
         S_HOLD: begin
            if (i_branch || !i_stall) begin
               valid_d = 1'b0;
               pc_d    = next_pc;
`ifdef PRCO_FETCH_HALT_EN
               if (!i_branch && instr_q[15:11] == 5'h1F) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
                  req_d    = 1'b0;
               end else
`endif
               if (i_en) begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  addr_d  = next_pc;
               end else begin
                  state_d = S_IDLE;
                  req_d   = 1'b0;
               end
            end
         end
`ifdef PRCO_FETCH_HALT_EN
         S_HALT: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         instr_q <= 16'h0000;
         valid_q <= 1'b0;
         ipc_q   <= RESET_PC;
         kill_q  <= 1'b0;
`ifdef PRCO_FETCH_HALT_EN
         halted_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         ipc_q   <= ipc_d;
         kill_q  <= kill_d;
`ifdef PRCO_FETCH_HALT_EN
         halted_q <= halted_d;
`endif
      end
   end

   assign q_mem_req     = req_q;
   assign q_mem_addr    = addr_q;
   assign q_instr       = instr_q;
   assign q_instr_valid = valid_q;
   assign q_pc          = ipc_q;
   assign q_state       = state_q;
`ifdef PRCO_FETCH_HALT_EN
   assign q_halted      = halted_q;
`else
   assign q_halted      = 1'b0;
`endif

endmodule

// File: tb/tb_prco_fetch.sv
// Directed bench for prco_fetch: a vector table for the main fetch/branch/stall
// behaviour, then hand sequences for halt handling and RESET_PC wrap-around.
module tb_prco_fetch;

   logic        clk = 1'b0;
   logic        rst, en, stall, br, ack;
   logic [15:0] tgt, data;

   logic        req0, vld0, halt0, req1, vld1, halt1;
   logic [15:0] addr0, instr0, pc0, addr1, instr1, pc1;
   logic [1:0]  st0, st1;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   prco_fetch #(.RESET_PC(16'h0000)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_stall(stall), .i_branch(br),
      .i_branch_target(tgt), .q_mem_req(req0), .q_mem_addr(addr0),
      .i_mem_ack(ack), .i_mem_data(data), .q_instr(instr0),
      .q_instr_valid(vld0), .q_pc(pc0), .q_halted(halt0), .q_state(st0)
   );

   prco_fetch #(.RESET_PC(16'hFFFF)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_stall(stall), .i_branch(br),
      .i_branch_target(tgt), .q_mem_req(req1), .q_mem_addr(addr1),
      .i_mem_ack(ack), .i_mem_data(data), .q_instr(instr1),
      .q_instr_valid(vld1), .q_pc(pc1), .q_halted(halt1), .q_state(st1)
   );

   typedef struct {
      logic        rst, en, stall, br;
      logic [15:0] tgt;
      logic        ack;
      logic [15:0] data;
      logic        ereq;
      logic [15:0] eaddr, einstr;
      logic        evld;
      logic [15:0] epc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic r, input logic e, input logic s, input logic b,
                        input logic [15:0] t, input logic a, input logic [15:0] d);
      rst = r; en = e; stall = s; br = b; tgt = t; ack = a; data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic e, input logic s, input logic b,
                      input logic [15:0] t, input logic a, input logic [15:0] d,
                      input logic q, input logic [15:0] ad, input logic [15:0] in,
                      input logic v, input logic [15:0] p);
      vecs.push_back('{r, e, s, b, t, a, d, q, ad, in, v, p});
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; ack = 1'b0; data = '0;
      //   rst en st br tgt       ack data     | req addr      instr     vld pc
      add(1, 0, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 16'h0000, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0000, 16'h0000, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 1, 16'h0801,   0, 16'h0000, 16'h0801, 1, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 16'h0801, 1, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 1, 16'h7777,   0, 16'h0000, 16'h0801, 1, 16'h0000);
      add(0, 1, 1, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 16'h0801, 1, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0001, 16'h0801, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 1, 16'h1002,   0, 16'h0001, 16'h1002, 1, 16'h0001);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0002, 16'h1002, 0, 16'h0001);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0002, 16'h1002, 0, 16'h0001);
      add(0, 1, 0, 0, 16'h0000, 1, 16'h3333,   0, 16'h0002, 16'h3333, 1, 16'h0002);
      add(0, 0, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0002, 16'h3333, 0, 16'h0002);
      add(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF,   0, 16'h0002, 16'h3333, 0, 16'h0002);
      add(0, 1, 0, 1, 16'h0005, 0, 16'h0000,   1, 16'h0005, 16'h3333, 0, 16'h0002);
      add(0, 1, 0, 1, 16'h0040, 0, 16'h0000,   1, 16'h0005, 16'h3333, 0, 16'h0002);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0005, 16'h3333, 0, 16'h0002);
      add(0, 1, 0, 0, 16'h0000, 1, 16'hBEEF,   1, 16'h0040, 16'h3333, 0, 16'h0002);
      add(0, 1, 0, 0, 16'h0000, 1, 16'h1234,   0, 16'h0040, 16'h1234, 1, 16'h0040);
      add(0, 1, 1, 1, 16'h0100, 0, 16'h0000,   1, 16'h0100, 16'h1234, 0, 16'h0040);
      add(0, 1, 0, 1, 16'h0200, 1, 16'h5555,   1, 16'h0200, 16'h1234, 0, 16'h0040);
      add(0, 0, 0, 0, 16'h0000, 1, 16'h6666,   0, 16'h0200, 16'h6666, 1, 16'h0200);
      add(0, 0, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0200, 16'h6666, 0, 16'h0200);
      add(0, 0, 0, 1, 16'h0300, 0, 16'h0000,   0, 16'h0200, 16'h6666, 0, 16'h0200);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0300, 16'h6666, 0, 16'h0200);
      add(1, 1, 0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 16'h0000, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0000, 16'h0000, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 1, 16'h0007,   0, 16'h0000, 16'h0007, 1, 16'h0000);
      add(0, 0, 1, 1, 16'h0400, 0, 16'h0000,   0, 16'h0000, 16'h0007, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0400, 16'h0007, 0, 16'h0000);
      add(0, 0, 0, 1, 16'h0500, 0, 16'h0000,   1, 16'h0400, 16'h0007, 0, 16'h0000);
      add(0, 0, 0, 0, 16'h0000, 1, 16'h9999,   0, 16'h0400, 16'h0007, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0500, 16'h0007, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 1, 16'hABCD,   0, 16'h0500, 16'hABCD, 1, 16'h0500);

      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].stall, vecs[i].br,
               vecs[i].tgt, vecs[i].ack, vecs[i].data);
         check($sformatf("row%0d req", i),   {15'd0, req0},  {15'd0, vecs[i].ereq});
         check($sformatf("row%0d addr", i),  addr0,          vecs[i].eaddr);
         check($sformatf("row%0d instr", i), instr0,         vecs[i].einstr);
         check($sformatf("row%0d valid", i), {15'd0, vld0},  {15'd0, vecs[i].evld});
         check($sformatf("row%0d pc", i),    pc0,            vecs[i].epc);
         check($sformatf("row%0d halted", i), {15'd0, halt0}, 16'd0);
      end

      // Halt opcode 16'hF800 reaching decode.
      drive(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
      drive(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      check("halt req0", {15'd0, req0}, 16'd1);
      drive(0, 1, 0, 0, 16'h0000, 1, 16'hF800);
      check("halt instr", instr0, 16'hF800);
      drive(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
`ifdef PRCO_FETCH_HALT_EN
      check("halt halted", {15'd0, halt0}, 16'd1);
      check("halt noreq", {15'd0, req0}, 16'd0);
      check("halt novalid", {15'd0, vld0}, 16'd0);
      drive(0, 1, 0, 1, 16'h0040, 1, 16'h1111);
      check("halt br halted", {15'd0, halt0}, 16'd1);
      check("halt br noreq", {15'd0, req0}, 16'd0);
      drive(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      check("halt stay noreq", {15'd0, req0}, 16'd0);
      check("halt stay novalid", {15'd0, vld0}, 16'd0);
      drive(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
      check("halt reset", {15'd0, halt0}, 16'd0);
      drive(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      check("halt restart req", {15'd0, req0}, 16'd1);
      check("halt restart addr", addr0, 16'h0000);
`else
      check("nohalt halted", {15'd0, halt0}, 16'd0);
      check("nohalt req", {15'd0, req0}, 16'd1);
      check("nohalt addr", addr0, 16'h0001);
      drive(0, 1, 0, 0, 16'h0000, 1, 16'h0022);
      check("nohalt instr", instr0, 16'h0022);
      check("nohalt pc", pc0, 16'h0001);
      check("nohalt valid", {15'd0, vld0}, 16'd1);
`endif

      // RESET_PC = 16'hFFFF: consecutive fetches wrap to 16'h0000.
      drive(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
      check("wrap reset pc", pc1, 16'hFFFF);
      check("wrap reset addr", addr1, 16'hFFFF);
      drive(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      check("wrap req1 addr", addr1, 16'hFFFF);
      check("wrap req1", {15'd0, req1}, 16'd1);
      drive(0, 1, 0, 0, 16'h0000, 1, 16'h0011);
      check("wrap instr1", instr1, 16'h0011);
      check("wrap pc1", pc1, 16'hFFFF);
      drive(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      check("wrap req2 addr", addr1, 16'h0000);
      drive(0, 1, 0, 0, 16'h0000, 1, 16'h0022);
      check("wrap instr2", instr1, 16'h0022);
      check("wrap pc2", pc1, 16'h0000);
      check("wrap valid2", {15'd0, vld1}, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/prco_fetch.md
PRCO_FETCH -- requirements
Module: prco_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_en  input  1  fetch enable; low means no new memory request is issued.
REQ-005 i_stall  input  1  downstream decoder not ready; holds the presented instruction.
REQ-006 i_branch  input  1  redirect strobe, one cycle.
REQ-007 i_branch_target  input  16  word address to redirect to.
REQ-008 q_mem_req  output  1  instruction memory request.
REQ-009 q_mem_addr  output  16  word address of the outstanding request.
REQ-010 i_mem_ack  input  1  memory completes the outstanding request this cycle.
REQ-011 i_mem_data  input  16  instruction word, valid when i_mem_ack=1.
REQ-012 q_instr  output  16  instruction presented to the decoder (i_instr of the decode stage).
REQ-013 q_instr_valid  output  1  q_instr holds a valid, unconsumed instruction.
REQ-014 q_pc  output  16  word address of q_instr.
REQ-015 q_halted  output  1  fetch halted.

Function
REQ-016 All outputs SHALL be registered; states S_IDLE, S_REQ, S_HOLD and S_HALT (S_HALT only with the macro).
REQ-017 Internal pc (16 bit) SHALL hold the next fetch address; increment +1 with wrap 16'hFFFF -> 16'h0000.
REQ-018 S_IDLE with i_en=1: next cycle S_REQ, q_mem_req=1, q_mem_addr=pc.
REQ-019 S_REQ: q_mem_req and q_mem_addr SHALL stay stable until a cycle with i_mem_ack=1.
REQ-020 S_REQ with ack and no kill: next cycle q_instr=i_mem_data, q_instr_valid=1, q_pc=q_mem_addr, pc=q_mem_addr+1, q_mem_req=0, state S_HOLD.
REQ-021 An instruction is consumed in any cycle with q_instr_valid=1 and i_stall=0.
REQ-022 S_HOLD with i_stall=1: q_instr, q_pc and q_instr_valid held unchanged.
REQ-023 S_HOLD on consume: q_instr_valid=0 next cycle; if i_en=1, go to S_REQ with q_mem_req=1 and q_mem_addr=pc on the same edge; else go to S_IDLE.
REQ-024 i_branch SHALL take priority over every other event in the same cycle: pc=i_branch_target, and q_instr_valid=0 next cycle.
REQ-025 i_branch in S_REQ without ack: set internal kill flag; the request continues unchanged; the matching ack's data SHALL be discarded; the kill flag is cleared; then go to S_REQ at the new pc if i_en=1, else S_IDLE.
REQ-026 i_branch coincident with ack: data discarded, no kill set; next state S_REQ at i_branch_target if i_en=1, else S_IDLE.
REQ-027 i_branch in S_HOLD: held instruction dropped; next state S_REQ at target if i_en=1, else S_IDLE.
REQ-028 i_branch in S_IDLE: pc=target; state transitions per REQ-018.
REQ-029 i_en falling while a request is outstanding: the request SHALL complete normally; no further request is issued.
REQ-030 i_mem_ack outside S_REQ SHALL be ignored.

Reset
REQ-031 With i_reset=1 at an edge: state=S_IDLE, pc=RESET_PC, q_mem_req=0, q_mem_addr=RESET_PC, q_instr=16'h0000, q_instr_valid=0, q_pc=RESET_PC, q_halted=0, kill flag=0.
REQ-032 Reset during an outstanding request SHALL abandon the request; the memory tolerates a dropped request.

Configuration
REQ-033 Macro PRCO_FETCH_HALT_EN defined: consuming an instruction with [15:11]=5'h1F SHALL enter S_HALT next cycle, with q_halted=1, q_mem_req=0, and i_branch and i_en ignored; only reset exits.
REQ-034 Macro PRCO_FETCH_HALT_EN undefined: opcode 5'h1F is fetched like any other instruction, S_HALT does not exist, and q_halted is constant 0.

Verification
REQ-035 Reset, i_en=1, ack one cycle after each request, data 16'h0801/16'h1002 -> q_instr 16'h0801 with q_pc 0, then 16'h1002 with q_pc 1; q_mem_addr 0 then 1.
REQ-036 i_stall=1 for 3 cycles while 16'h0801 is presented -> q_instr, q_pc and q_instr_valid stable; no q_mem_req until the cycle after i_stall=0.
REQ-037 i_branch with target 16'h0040 while in S_REQ at addr 5, ack 2 cycles later with 16'hBEEF -> 16'hBEEF never valid; next request addr 16'h0040.
REQ-038 RESET_PC=16'hFFFF, two fetches -> q_pc 16'hFFFF then 16'h0000.
REQ-039 Halt macro defined, instruction 16'hF800 consumed -> q_halted=1 and no further q_mem_req; a branch is ignored; reset clears it. Macro undefined -> fetch continues at the next address.
REQ-040 i_reset asserted while q_mem_req=1 -> q_mem_req=0 and q_instr_valid=0 next cycle, and fetch restarts at RESET_PC.
